// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for common-anode seven-segment digits that
// share a single external decoder. The displayed value lives in a shadow
// register that is only replaced at a frame boundary, so a frame never shows a
// half-updated number. New values wait in a one-deep pending buffer.
module seven_seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic                  lz_en,
  output logic [3:0]            hex_out,
  input  logic [6:0]            dec_seg,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] shd_val_r;
  logic [DIGITS-1:0]   shd_dp_r;
  logic [4*DIGITS-1:0] pnd_val_r;
  logic [DIGITS-1:0]   pnd_dp_r;
  logic                pnd_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;
  logic                fd_r;

  logic                slot_last_s;
  logic                frame_last_s;
  logic                load_fire_s;
  logic [DIGITS-1:0]   nib_nz_s;
  logic                upper_nz_s;
  logic                blank_s;
  logic [DIGITS-1:0]   an_s;

  assign slot_last_s  = (cnt_r == CNT_LAST);
  assign frame_last_s = slot_last_s && (idx_r == IDX_LAST);
  assign load_fire_s  = load_valid && !pnd_r;

  // Current digit nibble goes straight from the shadow to the shared decoder.
  assign hex_out = shd_val_r[{idx_r, 2'b00} +: 4];

  // Flag every non-zero nibble of the shadow value.
  always_comb begin
    nib_nz_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      nib_nz_s[k] = |shd_val_r[4*k +: 4];
    end
  end

  assign upper_nz_s = |(nib_nz_s >> idx_r);

  // Leading-zero blanking: digit 0 always shows; higher digits blank when they
  // and everything above them are zero.
  always_comb begin
    if (lz_en && (idx_r != IDX_ZERO) && !upper_nz_s) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
  end

  // Anode pattern: all off during the inter-digit gap, else only the current digit on.
  always_comb begin
    an_s = {DIGITS{1'b1}};
    if (cnt_r < CNT_BLANK) begin
      an_s = {DIGITS{1'b1}};
    end else begin
      an_s[idx_r] = 1'b0;
    end
  end

  // Slot counter and digit index advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
      idx_r <= IDX_ZERO;
    end else if (slot_last_s) begin
      cnt_r <= CNT_ZERO;
      idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Load handshake into the pending buffer and frame-boundary commit to the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_val_r <= {(4*DIGITS){1'b0}};
      shd_dp_r  <= {DIGITS{1'b0}};
      pnd_val_r <= {(4*DIGITS){1'b0}};
      pnd_dp_r  <= {DIGITS{1'b0}};
      pnd_r     <= 1'b0;
    end else if (frame_last_s && pnd_r) begin
      shd_val_r <= pnd_val_r;
      shd_dp_r  <= pnd_dp_r;
      pnd_r     <= 1'b0;
    end else if (load_fire_s) begin
      pnd_val_r <= load_value;
      pnd_dp_r  <= load_dp;
      pnd_r     <= 1'b1;
    end
  end

  // Pin outputs registered one stage behind the scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= {DIGITS{1'b1}};
      fd_r  <= 1'b0;
    end else begin
      seg_r <= blank_s ? 7'h7F : dec_seg;
      dp_r  <= ~shd_dp_r[idx_r];
      an_r  <= an_s;
      fd_r  <= frame_last_s;
    end
  end

  assign load_ready = ~pnd_r;
  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign an_out     = an_r;
  assign frame_done = fd_r;

endmodule
